// File: rtl/note_scan_display_pkg.sv
// Shared constants for the multiplexed note display: note divider table,
// seven-segment codes and the decoded-note record.
package note_display_pkg;

    localparam int DIV_W = 22;

    typedef logic [DIV_W-1:0] div_t;

    // Low-octave dividers, scale degrees 1..7
    localparam div_t DIV_L1 = 22'd191570;
    localparam div_t DIV_L2 = 22'd170648;
    localparam div_t DIV_L3 = 22'd151515;
    localparam div_t DIV_L4 = 22'd143266;
    localparam div_t DIV_L5 = 22'd127551;
    localparam div_t DIV_L6 = 22'd113636;
    localparam div_t DIV_L7 = 22'd101215;

    // High-octave dividers, scale degrees 1..7
    localparam div_t DIV_H1 = 22'd95420;
    localparam div_t DIV_H2 = 22'd85034;
    localparam div_t DIV_H3 = 22'd75758;
    localparam div_t DIV_H4 = 22'd71633;
    localparam div_t DIV_H5 = 22'd63776;
    localparam div_t DIV_H6 = 22'd56818;
    localparam div_t DIV_H7 = 22'd50607;

    // Active-low segment codes {a,b,c,d,e,f,g,dp}
    localparam logic [7:0] SS_1     = 8'b1001_1111;
    localparam logic [7:0] SS_2     = 8'b0010_0101;
    localparam logic [7:0] SS_3     = 8'b0000_1101;
    localparam logic [7:0] SS_4     = 8'b1001_1001;
    localparam logic [7:0] SS_5     = 8'b0100_1001;
    localparam logic [7:0] SS_6     = 8'b0100_0001;
    localparam logic [7:0] SS_7     = 8'b0001_1011;
    localparam logic [7:0] SS_L     = 8'b1110_0011;
    localparam logic [7:0] SS_H     = 8'b1001_0001;
    localparam logic [7:0] SS_BLANK = 8'hFF;

    // Decoded note: oct=0 is the low octave (L), oct=1 the high octave (H)
    typedef struct packed {
        logic       valid;
        logic [2:0] deg;
        logic       oct;
    } note_t;

    // Segment code for a scale degree; anything outside 1..7 is blank
    function automatic logic [7:0] deg_code(input logic [2:0] deg);
        logic [7:0] code;
        case (deg)
            3'd1:    code = SS_1;
            3'd2:    code = SS_2;
            3'd3:    code = SS_3;
            3'd4:    code = SS_4;
            3'd5:    code = SS_5;
            3'd6:    code = SS_6;
            3'd7:    code = SS_7;
            default: code = SS_BLANK;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/note_scan_display_if.sv
// Bus between the tone generators / board pins and the note scan display.
interface note_scan_display_if
    import note_display_pkg::*;
#(
    parameter int NUM_CH = 2
);

    logic [DIV_W*NUM_CH-1:0] note_div;
    logic                    mute;
    logic [7:0]              show;
    logic [2*NUM_CH-1:0]     ssd_ctrl;

    modport master (output note_div, output mute, input show, input ssd_ctrl);
    modport slave  (input note_div, input mute, output show, output ssd_ctrl);

endinterface

// File: rtl/note_scan_display_decode.sv
// Exact-match decode of one note divider into scale degree and octave.
module note_decode
    import note_display_pkg::*;
(
    input  div_t  div,
    output note_t note
);

    // Table lookup; any divider not in the table (including rest = 0) is invalid
    always_comb begin
        note = '0;
        case (div)
            DIV_L1: note = {1'b1, 3'd1, 1'b0};
            DIV_L2: note = {1'b1, 3'd2, 1'b0};
            DIV_L3: note = {1'b1, 3'd3, 1'b0};
            DIV_L4: note = {1'b1, 3'd4, 1'b0};
            DIV_L5: note = {1'b1, 3'd5, 1'b0};
            DIV_L6: note = {1'b1, 3'd6, 1'b0};
            DIV_L7: note = {1'b1, 3'd7, 1'b0};
            DIV_H1: note = {1'b1, 3'd1, 1'b1};
            DIV_H2: note = {1'b1, 3'd2, 1'b1};
            DIV_H3: note = {1'b1, 3'd3, 1'b1};
            DIV_H4: note = {1'b1, 3'd4, 1'b1};
            DIV_H5: note = {1'b1, 3'd5, 1'b1};
            DIV_H6: note = {1'b1, 3'd6, 1'b1};
            DIV_H7: note = {1'b1, 3'd7, 1'b1};
            default: note = '0;
        endcase
    end

endmodule

// File: rtl/note_scan_display.sv
// Multi-channel note display: decodes each channel's divider, holds the last
// note for a few scan frames after a rest, and scans degree/octave digits
// across an active-low seven-segment display.
module note_scan_display
    import note_display_pkg::*;
#(
    parameter int NUM_CH       = 2,
    parameter int DIGIT_CYCLES = 100000,
    parameter int HOLD_FRAMES  = 8
) (
    input logic                clk,
    input logic                rst_n,
    note_scan_display_if.slave bus
);

    localparam int NUM_DIGITS = 2 * NUM_CH;
    localparam int CNT_W      = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int HC_W       = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;

    logic [DIV_W*NUM_CH-1:0] note_div_p0;
    note_t                   dec_p0 [NUM_CH];

    logic                    disp_vld_p1 [NUM_CH];
    logic                    held_p1     [NUM_CH];
    logic [HC_W-1:0]         hold_cnt_p1 [NUM_CH];
    logic [2:0]              disp_deg_p1 [NUM_CH];
    logic                    disp_oct_p1 [NUM_CH];

    logic [CNT_W-1:0]        scan_cnt;
    logic [IDX_W-1:0]        digit_idx;
    logic                    scan_wrap;
    logic                    frame_tick;

    logic [7:0]              digit_code;
    logic [7:0]              deg_seg;

    // ---- stage 1: capture raw dividers ----
    // Dividers are pure data and need no reset
    always_ff @(posedge clk) begin
        note_div_p0 <= bus.note_div;
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_dec
        note_decode u_dec (
            .div  (note_div_p0[DIV_W*k +: DIV_W]),
            .note (dec_p0[k])
        );
    end

    // ---- scan timing ----
    assign scan_wrap  = (scan_cnt == CNT_W'(DIGIT_CYCLES - 1));
    assign frame_tick = scan_wrap && (digit_idx == IDX_W'(NUM_DIGITS - 1));

    // Per-digit dwell counter and digit index advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt  <= '0;
            digit_idx <= '0;
        end else if (scan_wrap) begin
            scan_cnt  <= '0;
            digit_idx <= (digit_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : digit_idx + 1'b1;
        end else begin
            scan_cnt  <= scan_cnt + 1'b1;
        end
    end

    // ---- stage 2: per-channel display state with hold-after-rest ----
    // A fresh valid note always wins over a coincident frame tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_CH; k++) begin
                disp_vld_p1[k] <= 1'b0;
                held_p1[k]     <= 1'b0;
                hold_cnt_p1[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (dec_p0[k].valid) begin
                    disp_vld_p1[k] <= 1'b1;
                    held_p1[k]     <= 1'b0;
                    hold_cnt_p1[k] <= HC_W'(HOLD_FRAMES);
                end else if (disp_vld_p1[k]) begin
                    held_p1[k] <= 1'b1;
                    if (HOLD_FRAMES == 0) begin
                        disp_vld_p1[k] <= 1'b0;
                    end else if (frame_tick) begin
                        if (hold_cnt_p1[k] == '0) begin
                            disp_vld_p1[k] <= 1'b0;
                        end else begin
                            hold_cnt_p1[k] <= hold_cnt_p1[k] - 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Degree/octave payload follows the decoder only when a note is present
    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_CH; k++) begin
            if (dec_p0[k].valid) begin
                disp_deg_p1[k] <= dec_p0[k].deg;
                disp_oct_p1[k] <= dec_p0[k].oct;
            end
        end
    end

    // Select the segment pattern for the digit currently being scanned
    always_comb begin
        digit_code = SS_BLANK;
        deg_seg    = SS_BLANK;
        for (int k = 0; k < NUM_CH; k++) begin
            if (digit_idx == IDX_W'(2 * k)) begin
                deg_seg    = deg_code(disp_deg_p1[k]);
                deg_seg[0] = ~held_p1[k];
                digit_code = disp_vld_p1[k] ? deg_seg : SS_BLANK;
            end
            if (digit_idx == IDX_W'(2 * k + 1)) begin
                digit_code = !disp_vld_p1[k] ? SS_BLANK :
                             (disp_oct_p1[k] ? SS_H : SS_L);
            end
        end
    end

    // ---- stage 3: registered pin drivers ----
    // Mute blanks segments but leaves the digit scan running
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.show     <= SS_BLANK;
            bus.ssd_ctrl <= '1;
        end else begin
            bus.ssd_ctrl <= ~(NUM_DIGITS'(1) << digit_idx);
            bus.show     <= bus.mute ? SS_BLANK : digit_code;
        end
    end

endmodule

// File: tb/tb_note_scan_display.sv
// Bench for note_scan_display: directed scan, hold, mute and reset sequences
// with a per-cycle expected-pin scoreboard.
module tb_note_scan_display;

    localparam int NUM_CH       = 2;
    localparam int DIGIT_CYCLES = 4;
    localparam int HOLD_FRAMES  = 2;
    localparam int FRAME        = DIGIT_CYCLES * 2 * NUM_CH;

    localparam logic [21:0] D_L1 = 22'd191570;
    localparam logic [21:0] D_L5 = 22'd127551;
    localparam logic [21:0] D_H6 = 22'd56818;
    localparam logic [21:0] D_XX = 22'd123456;

    localparam logic [7:0] C_1   = 8'b1001_1111;
    localparam logic [7:0] C_5   = 8'b0100_1001;
    localparam logic [7:0] C_5DP = 8'b0100_1000;
    localparam logic [7:0] C_6   = 8'b0100_0001;
    localparam logic [7:0] C_L   = 8'b1110_0011;
    localparam logic [7:0] C_H   = 8'b1001_0001;
    localparam logic [7:0] C_BL  = 8'hFF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [21:0] ch0_div = '0;
    logic [21:0] ch1_div = '0;
    logic        mute_in = 1'b0;

    note_scan_display_if #(.NUM_CH(NUM_CH)) bus ();

    assign bus.note_div = {ch1_div, ch0_div};
    assign bus.mute     = mute_in;

    note_scan_display #(
        .NUM_CH       (NUM_CH),
        .DIGIT_CYCLES (DIGIT_CYCLES),
        .HOLD_FRAMES  (HOLD_FRAMES)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] ctrl;
        logic [7:0] show;
        logic       chk;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   edges       = 0;

    task automatic check_pins(input string tag, input logic [7:0] es, input logic [3:0] ec);
        vectors++;
        assert (bus.show === es) else begin
            miscompares++;
            $error("FAIL %s show: got %b expected %b", tag, bus.show, es);
        end
        vectors++;
        assert (bus.ssd_ctrl === ec) else begin
            miscompares++;
            $error("FAIL %s ssd_ctrl: got %b expected %b", tag, bus.ssd_ctrl, ec);
        end
    endtask

    // One clock: queue the expected pins for this edge, then compare after it
    task automatic step(input logic [7:0] d0, input logic [7:0] d1,
                        input logic [7:0] d2, input logic [7:0] d3,
                        input logic chk, input logic m);
        logic [7:0] d [4];
        int         idx;
        exp_t       e;
        d      = '{d0, d1, d2, d3};
        idx    = (edges / DIGIT_CYCLES) % 4;
        e.ctrl = ~(4'b0001 << idx);
        e.show = m ? C_BL : d[idx];
        e.chk  = chk;
        mute_in = m;
        sb.push_back(e);
        @(posedge clk);
        edges++;
        @(negedge clk);
        e = sb.pop_front();
        vectors++;
        assert (bus.ssd_ctrl === e.ctrl) else begin
            miscompares++;
            $error("FAIL ssd_ctrl edge %0d: got %b expected %b", edges, bus.ssd_ctrl, e.ctrl);
        end
        if (e.chk) begin
            vectors++;
            assert (bus.show === e.show) else begin
                miscompares++;
                $error("FAIL show edge %0d: got %b expected %b", edges, bus.show, e.show);
            end
        end
    endtask

    // Asynchronous reset asserted between clock edges
    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_pins("reset_async", C_BL, 4'hF);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_pins("reset_hold", C_BL, 4'hF);
        rst_n = 1'b1;
        edges = 0;
    endtask

    // Drop ch0 to rest on a frame boundary; optionally re-apply it so the
    // note returns on the frame tick that would otherwise blank it
    task automatic hold_seq(input bit reapply);
        logic [7:0] d0;
        logic [7:0] d1;
        for (int j = 0; j < 4 * FRAME; j++) begin
            if (j == 0) ch0_div = '0;
            if (reapply && j == 3 * FRAME - 2) ch0_div = D_L5;
            d0 = (j < 2) ? C_5 : (j < 3 * FRAME) ? C_5DP : (reapply ? C_5 : C_BL);
            d1 = (j < 3 * FRAME || reapply) ? C_L : C_BL;
            step(d0, d1, C_6, C_H, 1'b1, 1'b0);
        end
    endtask

    // Bring ch0 back to L5 from blank, starting on a frame boundary
    task automatic restore_seq();
        for (int j = 0; j < FRAME; j++) begin
            if (j == 0) ch0_div = D_L5;
            step((j < 2) ? C_BL : C_5, (j < 2) ? C_BL : C_L, C_6, C_H, 1'b1, 1'b0);
        end
    endtask

    initial begin
        int settle;
        ch0_div = D_L1;
        ch1_div = D_XX;
        do_reset();

        // ch0 = L1, ch1 unknown divider: ch1 digits stay blank
        for (int j = 0; j < 2 * FRAME; j++)
            step(C_1, C_L, C_BL, C_BL, (j >= 2), 1'b0);

        // ch1 = H6
        ch1_div = D_H6;
        for (int j = 0; j < 3; j++) step(C_1, C_L, C_6, C_H, 1'b0, 1'b0);
        for (int j = 0; j < FRAME; j++) step(C_1, C_L, C_6, C_H, 1'b1, 1'b0);

        // ch0 = L5, settle and align to a frame boundary
        ch0_div = D_L5;
        settle = 0;
        while (settle < 3 || (edges % FRAME) != 0) begin
            step(C_5, C_L, C_6, C_H, 1'b0, 1'b0);
            settle++;
        end
        for (int j = 0; j < FRAME; j++) step(C_5, C_L, C_6, C_H, 1'b1, 1'b0);

        // Hold for three frame ticks then blank
        hold_seq(1'b0);
        restore_seq();
        // Re-apply on the blanking tick: stays lit, hold counter reloads
        hold_seq(1'b1);
        // Full hold again proves the counter was reloaded
        hold_seq(1'b0);
        restore_seq();

        // Mute pulse: segments blank, scan continues
        for (int j = 0; j < 5; j++)  step(C_5, C_L, C_6, C_H, 1'b1, 1'b0);
        for (int j = 0; j < 10; j++) step(C_5, C_L, C_6, C_H, 1'b1, 1'b1);
        for (int j = 0; j < 10; j++) step(C_5, C_L, C_6, C_H, 1'b1, 1'b0);

        // Reset mid-scan, then scanning restarts at digit 0
        do_reset();
        for (int j = 0; j < 20; j++) step(C_5, C_L, C_6, C_H, (j >= 2), 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/note_scan_display.md
Name: note_scan_display

Overview:
Multi-channel, time-multiplexed successor to the single-digit note display. It decodes each channel's 22-bit note divider into a scale degree (1-7) and an octave (L/H). It scans the results across a 4-digit (default) active-low seven-segment display. It holds the last note for a programmable number of scan frames after a rest, marking held notes with the decimal point. It sits between the music/tone generators and the board SSD pins.

Parameters:
NUM_CH, 2, number of note channels; each channel uses 2 digits, so NUM_DIGITS = 2*NUM_CH
DIGIT_CYCLES, 100000, clock cycles each digit stays enabled (>=2)
HOLD_FRAMES, 8, full scan frames a note stays displayed after its divider leaves the table (0 = blank immediately)

Ports:
clk  in  1  system clock
rst_n  in  1  reset; asynchronous, active-low
note_div  in  22*NUM_CH  packed dividers; channel k = bits [22k+21:22k]; 0 = rest
mute  in  1  1 = blank all segments; scanning continues
show  out  8  segments {a,b,c,d,e,f,g,dp}, active-low, registered
ssd_ctrl  out  NUM_DIGITS  digit enables, active-low one-hot, registered

Behaviour:
- Reset (async, rst_n=0): show=8'hFF, ssd_ctrl=all ones. Scan counter=0, digit index=0. All channel display registers invalid, hold counters=0. Reset mid-scan aborts immediately; there is no partial-frame carry-over.
- Stage 1: note_div registered every cycle (note_div_q).
- Decode (note_decode, combinational on note_div_q): exact match only.
  - Low octave: 191570/170648/151515/143266/127551/113636/101215 -> degrees 1..7, oct=L.
  - High octave: 95420/85034/75758/71633/63776/56818/50607 -> degrees 1..7, oct=H.
  - Any other value, including 0: valid=0.
- Stage 2, per channel: registers disp_vld, disp_deg[2:0], disp_oct, held, hold_cnt.
  - valid=1: load deg/oct, disp_vld=1, held=0, hold_cnt=HOLD_FRAMES.
  - valid=0 and disp_vld=1: held=1. On each frame_tick, if hold_cnt=0 then disp_vld=0, else hold_cnt-1.
  - HOLD_FRAMES=0: disp_vld clears on the cycle after valid drops, without waiting for frame_tick.
  - valid=1 coincident with frame_tick: reload wins.
- Scan counter: 0..DIGIT_CYCLES-1.
  - At DIGIT_CYCLES-1 it wraps and the digit index increments, wrapping NUM_DIGITS-1 -> 0.
  - frame_tick is a 1-cycle pulse when the index wraps to 0.
- Digit mapping: digit 2k = channel k degree; digit 2k+1 = channel k octave.
- Segment codes:
  - Degrees 1-7 use the established codes (1=8'b1001_1111 ... 7=8'b0001_1011).
  - L=8'b1110_0011, H=8'b1001_0001, blank=8'hFF.
  - The degree digit's dp bit is forced 0 while held=1.
  - disp_vld=0 -> both digits of that channel blank.
- Stage 3 (output register):
  - ssd_ctrl = ~(1<<index); show = code for index; mute=1 -> show=8'hFF, ssd_ctrl still scans.
  - Latency from note_div change to show: 3 cycles while the digit is active.
  - First cycle after rst_n rises: ssd_ctrl=...1110.

Decomposition:
- Package note_display_pkg holds:
  - the 14 divider constants
  - SS_1..SS_7, SS_L, SS_H, SS_BLANK
  - a DIV_W=22 constant
- Sub-module note_decode (one instance per channel) maps a divider to {valid, deg[2:0], oct}.
- Scan counter, hold logic and output mux stay in the top module.

Test Plan:
- Reset: hold rst_n=0 mid-scan, then release -> show=8'hFF and ssd_ctrl=all-ones during reset. 1 cycle after release ssd_ctrl=4'b1110; digits advance every DIGIT_CYCLES (use 4 in sim).
- ch0=191570, ch1=56818, DIGIT_CYCLES=4 -> digit0 8'b1001_1111, digit1 8'b1110_0011, digit2 8'b0100_0001, digit3 8'b1001_0001.
- ch0 127551 -> 0 with HOLD_FRAMES=2 -> digit0 shows 8'b0100_1000 (5 with dp) for 3 frame_ticks. It blanks to 8'hFF after the third tick; ch1 is unaffected.
- Unknown divider 123456 on ch1 from reset -> digits 2,3 stay 8'hFF for the whole run.
- mute=1 pulse for 10 cycles with valid notes -> show=8'hFF for exactly those cycles (+1 latency); the ssd_ctrl sequence is uninterrupted.
- Valid note re-applied on the same cycle as frame_tick with hold_cnt=0 -> disp_vld stays 1, dp clears, hold_cnt reloads to HOLD_FRAMES.
